// File: rtl/store_merge_unit.sv
// Store path of the data memory interface: places a byte/half/word into its lane(s)
// and merges it into the existing memory word by read-modify-write.
module store_merge_unit #(
    parameter int XLEN     = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [XLEN-1:0]     req_data,
    input  logic [1:0]          req_size,
    output logic                done,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_WRITE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [XLEN-1:0]     merged_q, merged_d;
    logic [1:0]          size_q, size_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                misaligned;

    // Overlay the store data onto the old word within the lane(s) selected by size/offset.
    function automatic logic [XLEN-1:0] merge_fn(
        input logic [XLEN-1:0] old_word,
        input logic [XLEN-1:0] st_data,
        input logic [1:0]      size,
        input logic [1:0]      off
    );
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] pos;
        case (size)
            2'b00: begin
                mask = XLEN'(8'hFF) << {off, 3'b000};
                pos  = XLEN'(st_data[7:0]) << {off, 3'b000};
            end
            2'b01: begin
                mask = XLEN'(16'hFFFF) << {off[1], 4'b0000};
                pos  = XLEN'(st_data[15:0]) << {off[1], 4'b0000};
            end
            default: begin
                mask = '1;
                pos  = st_data;
            end
        endcase
        return (old_word & ~mask) | (pos & mask);
    endfunction

    always_comb begin
        misaligned = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        size_d   = size_q;
        merged_d = merged_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = req_addr;
                        data_d = req_data;
                        size_d = req_size;
                        // Full-word stores need no read; the merged word is the data itself.
                        if (req_size == 2'b10) begin
                            merged_d = req_data;
                            state_d  = S_WRITE;
                        end else begin
                            state_d  = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                if (mem_gnt) state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (mem_rvalid) begin
                    merged_d = merge_fn(mem_rdata, data_q, size_q, addr_q[1:0]);
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_gnt) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            size_q   <= 2'b00;
            merged_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            size_q   <= size_d;
            merged_q <= merged_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_READ) | (state_q == S_WRITE);
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = {addr_q[ADDR_LEN-1:2], 2'b00};
    assign mem_wdata = merged_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with a small word-memory responder
// that has configurable grant wait and read-data delay.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = 2'b00;
    logic        done, err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'hDEAD_DEAD;

    store_merge_unit #(.XLEN(32), .ADDR_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [logic [31:0]];
    int          gnt_wait = 0;
    int          rv_delay = 0;
    int          rd_count = 0;
    int          wr_count = 0;
    int          req_cycles = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory responder: acts on the falling edge, DUT sees its outputs on the next rising edge.
    initial begin
        bit          in_txn = 0;
        bit          rv_pend = 0;
        int          wait_cnt = 0;
        int          rv_cnt = 0;
        logic [31:0] rv_addr = '0;
        logic        s_we = 1'b0;
        logic [31:0] s_addr = '0;
        logic [31:0] s_wdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_DEAD;
            if (!rst_n) begin
                in_txn  = 0;
                rv_pend = 0;
            end else begin
                if (rv_pend) begin
                    if (rv_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem.exists(rv_addr) ? mem[rv_addr] : 32'h0;
                        rv_pend    = 0;
                    end else begin
                        rv_cnt--;
                    end
                end
                if (mem_req) begin
                    req_cycles++;
                    if (!in_txn) begin
                        in_txn   = 1;
                        wait_cnt = gnt_wait;
                        s_we     = mem_we;
                        s_addr   = mem_addr;
                        s_wdata  = mem_wdata;
                    end else begin
                        check("stable_we", mem_we, s_we);
                        check("stable_addr", mem_addr, s_addr);
                        if (s_we) check("stable_wdata", mem_wdata, s_wdata);
                    end
                    if (wait_cnt == 0) begin
                        mem_gnt = 1'b1;
                        in_txn  = 0;
                        if (mem_we) begin
                            wr_count++;
                            last_waddr = mem_addr;
                            last_wdata = mem_wdata;
                            mem[mem_addr] = mem_wdata;
                        end else begin
                            rd_count++;
                            rv_pend = 1;
                            rv_cnt  = rv_delay;
                            rv_addr = mem_addr;
                        end
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // Call at a falling edge; presents the request for one rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_data  = 32'h0BAD_0BAD;
        req_size  = 2'b10;
    endtask

    // Cycle count where the accept cycle is 0; stops at the falling edge where done is high.
    task automatic wait_done(input int budget, output int cyc);
        cyc = 1;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input int exp_lat, input logic [31:0] exp_waddr, input logic [31:0] exp_wdata);
        int rc0, wc0, cyc;
        rc0 = rd_count;
        wc0 = wr_count;
        issue(a, d, s);
        wait_done(40, cyc);
        if (exp_lat > 0) check("latency", cyc, exp_lat);
        check("reads", rd_count - rc0, (s == 2'b10) ? 0 : 1);
        check("writes", wr_count - wc0, 1);
        check("waddr", last_waddr, exp_waddr);
        check("wdata", last_wdata, exp_wdata);
        @(negedge clk);
        check("done_once", done, 1'b0);
    endtask

    initial begin
        int rq0, wc0, cyc;
        logic seen;
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        mem[32'h1000] = 32'h1122_3344;
        store(32'h1003, 32'h0000_00AB, 2'b00, 4, 32'h1000, 32'hAB22_3344);

        mem[32'h2000] = 32'h1122_3344;
        store(32'h2002, 32'h0000_BEEF, 2'b01, 4, 32'h2000, 32'hBEEF_3344);
        mem[32'h2000] = 32'h1122_3344;
        store(32'h2000, 32'h0000_BEEF, 2'b01, 4, 32'h2000, 32'h1122_BEEF);

        store(32'h3000, 32'hDEAD_BEEF, 2'b10, 2, 32'h3000, 32'hDEAD_BEEF);

        rq0 = req_cycles;
        issue(32'h0001, 32'h1234_5678, 2'b01);
        check("err_half", err, 1'b1);
        check("err_half_ready", req_ready, 1'b1);
        issue(32'h0006, 32'h1234_5678, 2'b10);
        check("err_word", err, 1'b1);
        check("err_word_ready", req_ready, 1'b1);
        issue(32'h0008, 32'h1234_5678, 2'b11);
        check("err_size", err, 1'b1);
        check("err_size_ready", req_ready, 1'b1);
        @(negedge clk);
        check("err_pulse_end", err, 1'b0);
        check("err_no_mem_req", req_cycles - rq0, 0);

        gnt_wait = 3;
        rv_delay = 2;
        mem[32'h4000] = 32'h1122_3344;
        store(32'h4001, 32'hFFFF_FF55, 2'b00, 0, 32'h4000, 32'h1122_5544);
        gnt_wait = 0;

        rv_delay = 5;
        mem[32'h5000] = 32'hAABB_CCDD;
        issue(32'h5002, 32'h0000_0077, 2'b00);
        @(negedge clk);
        check("waitr_no_req", mem_req, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", req_ready, 1'b1);
        check("arst_mem_req", mem_req, 1'b0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_mem_wdata", mem_wdata, 32'h0);
        check("arst_done", done, 1'b0);
        wc0 = wr_count;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | done | err | mem_req;
        end
        check("arst_no_activity", seen, 1'b0);
        check("arst_no_write", wr_count - wc0, 0);
        rv_delay = 0;
        store(32'h5002, 32'h0000_0077, 2'b00, 4, 32'h5000, 32'hAA77_CCDD);

        issue(32'h3000, 32'h0102_0304, 2'b10);
        wait_done(40, cyc);
        check("b2b_ready", req_ready, 1'b1);
        issue(32'h3004, 32'hCAFE_F00D, 2'b10);
        wait_done(40, cyc);
        check("b2b_latency", cyc, 2);
        check("b2b_waddr", last_waddr, 32'h3004);
        check("b2b_wdata", last_wdata, 32'hCAFE_F00D);
        check("b2b_mem_prev", mem[32'h3000], 32'h0102_0304);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
